// File: rtl/vram_wr_arb.sv
// vram_wr_arb: shares the text-mode VRAM/CRAM write port between the SPI
// bridge (A), the DMA character writer (B) and a clear-screen fill engine.
// All outputs are registered; a decision taken at one clock edge is visible
// on the outputs for exactly the following cycle.
//
// state    | meaning
// ST_IDLE  | round-robin arbitration between A and B; i_clr_h starts a fill
// ST_FILL  | one fill write per cycle, address r_cnt, until CELLS-1 is written
module vram_wr_arb #(
  parameter int          ADDR_W    = 11,
  parameter int          CELLS     = 2000,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst_h,
  input  logic              i_a_req_h,
  input  logic [ADDR_W-1:0] i_a_adr,
  input  logic [7:0]        i_a_data,
  input  logic [7:0]        i_a_attr,
  output logic              o_a_ack_h,
  input  logic              i_b_req_h,
  input  logic [ADDR_W-1:0] i_b_adr,
  input  logic [7:0]        i_b_data,
  input  logic [7:0]        i_b_attr,
  output logic              o_b_ack_h,
  input  logic              i_clr_h,
  input  logic [7:0]        i_clr_attr,
  output logic              o_busy_h,
  output logic [ADDR_W-1:0] o_vram_adr,
  output logic [7:0]        o_vram_data,
  output logic [7:0]        o_cram_data,
  output logic              o_vram_we_h,
  output logic              o_err_h
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(CELLS - 1);
  // One extra bit so the range check also works when CELLS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W + 1)'(CELLS);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_attr;
  logic              r_rr_b;    // 0: A wins a tie, 1: B wins a tie

  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [7:0]        r_vdat;
  logic [7:0]        r_cdat;
  logic              r_a_ack;
  logic              r_b_ack;
  logic              r_err;
  logic              r_busy;

  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [7:0]        w_attr_nxt;
  logic              w_rr_b_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_adr;
  logic [7:0]        w_vdat;
  logic [7:0]        w_cdat;
  logic              w_a_ack;
  logic              w_b_ack;
  logic              w_err;
  logic              w_busy;
  logic              w_arb;

  logic              w_a_pend;
  logic              w_b_pend;
  logic              w_a_ok;
  logic              w_b_ok;
  logic              w_gnt_a;
  logic              w_gnt_b;

  // A request is not looked at while its own ack is on the bus, so a
  // requester that is still holding the acked request is not served twice.
  assign w_a_pend = i_a_req_h & ~r_a_ack;
  assign w_b_pend = i_b_req_h & ~r_b_ack;
  assign w_a_ok   = {1'b0, i_a_adr} < CELLS_W;
  assign w_b_ok   = {1'b0, i_b_adr} < CELLS_W;
  assign w_gnt_a  = w_a_pend & (~w_b_pend | ~r_rr_b);
  assign w_gnt_b  = w_b_pend & ~w_gnt_a;

  // Next-state and next-output decision: fill first, else arbitrate A/B.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_attr_nxt  = r_attr;
    w_rr_b_nxt  = r_rr_b;
    w_we        = 1'b0;
    w_adr       = '0;
    w_vdat      = 8'h00;
    w_cdat      = 8'h00;
    w_a_ack     = 1'b0;
    w_b_ack     = 1'b0;
    w_err       = 1'b0;
    w_busy      = 1'b0;
    w_arb       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_clr_h) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
          w_attr_nxt  = i_clr_attr;
          w_we        = 1'b1;
          w_adr       = '0;
          w_vdat      = FILL_CHAR;
          w_cdat      = i_clr_attr;
          w_busy      = 1'b1;
        end else begin
          w_arb = 1'b1;
        end
      end
      default: begin
        // The last fill write is on the outputs now; requesters may take
        // the very next slot, but a new clear is still ignored here.
        if (r_cnt == LAST_ADR) begin
          w_state_nxt = ST_IDLE;
          w_arb       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
          w_we      = 1'b1;
          w_adr     = r_cnt + ADDR_W'(1);
          w_vdat    = FILL_CHAR;
          w_cdat    = r_attr;
          w_busy    = 1'b1;
        end
      end
    endcase

    if (w_arb) begin
      if (w_gnt_a) begin
        w_a_ack    = 1'b1;
        w_rr_b_nxt = 1'b1;
        if (w_a_ok) begin
          w_we   = 1'b1;
          w_adr  = i_a_adr;
          w_vdat = i_a_data;
          w_cdat = i_a_attr;
        end else begin
          w_err = 1'b1;
        end
      end else if (w_gnt_b) begin
        w_b_ack    = 1'b1;
        w_rr_b_nxt = 1'b0;
        if (w_b_ok) begin
          w_we   = 1'b1;
          w_adr  = i_b_adr;
          w_vdat = i_b_data;
          w_cdat = i_b_attr;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // Register state and all outputs; synchronous reset aborts any fill.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_attr  <= 8'h00;
      r_rr_b  <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_vdat  <= 8'h00;
      r_cdat  <= 8'h00;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_attr  <= w_attr_nxt;
      r_rr_b  <= w_rr_b_nxt;
      r_we    <= w_we;
      r_adr   <= w_adr;
      r_vdat  <= w_vdat;
      r_cdat  <= w_cdat;
      r_a_ack <= w_a_ack;
      r_b_ack <= w_b_ack;
      r_err   <= w_err;
      r_busy  <= w_busy;
    end
  end

  assign o_vram_we_h = r_we;
  assign o_vram_adr  = r_adr;
  assign o_vram_data = r_vdat;
  assign o_cram_data = r_cdat;
  assign o_a_ack_h   = r_a_ack;
  assign o_b_ack_h   = r_b_ack;
  assign o_err_h     = r_err;
  assign o_busy_h    = r_busy;

endmodule

// File: tb/tb_vram_wr_arb.sv
// Testbench for vram_wr_arb: directed vector table, fill/reset sequences,
// then random traffic against a cycle-level behavioural model.
module tb_vram_wr_arb;

  localparam int AW    = 11;
  localparam int CELLS = 2000;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    vd;
    logic [7:0]    cd;
    logic          a_ack;
    logic          b_ack;
    logic          err;
    logic          busy;
  } outs_t;

  typedef struct packed {
    logic          a_req;
    logic [AW-1:0] a_adr;
    logic [7:0]    a_dat;
    logic [7:0]    a_att;
    logic          b_req;
    logic [AW-1:0] b_adr;
    logic [7:0]    b_dat;
    logic [7:0]    b_att;
    outs_t         exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, clr = 1'b0;
  logic [AW-1:0] a_adr = '0, b_adr = '0;
  logic [7:0]    a_dat = '0, a_att = '0, b_dat = '0, b_att = '0, clr_att = '0;
  logic          a_ack, b_ack, busy, we, err;
  logic [AW-1:0] v_adr;
  logic [7:0]    v_dat, c_dat;

  int n_pass  = 0;
  int n_total = 0;

  vram_wr_arb #(.ADDR_W(AW), .CELLS(CELLS), .FILL_CHAR(8'h20)) dut (
    .i_clk(clk), .i_rst_h(rst),
    .i_a_req_h(a_req), .i_a_adr(a_adr), .i_a_data(a_dat), .i_a_attr(a_att), .o_a_ack_h(a_ack),
    .i_b_req_h(b_req), .i_b_adr(b_adr), .i_b_data(b_dat), .i_b_attr(b_att), .o_b_ack_h(b_ack),
    .i_clr_h(clr), .i_clr_attr(clr_att), .o_busy_h(busy),
    .o_vram_adr(v_adr), .o_vram_data(v_dat), .o_cram_data(c_dat),
    .o_vram_we_h(we), .o_err_h(err)
  );

  always #5 clk = ~clk;

  function automatic outs_t mko(logic w, int adr, logic [7:0] vd, logic [7:0] cd,
                                logic aa, logic ba, logic e, logic bz);
    outs_t o;
    o.we = w; o.adr = AW'(adr); o.vd = vd; o.cd = cd;
    o.a_ack = aa; o.b_ack = ba; o.err = e; o.busy = bz;
    return o;
  endfunction

  function automatic vec_t mkv(logic ar, int aadr, logic [7:0] ad, logic [7:0] at,
                               logic br, int badr, logic [7:0] bd, logic [7:0] bt,
                               outs_t e);
    vec_t v;
    v.a_req = ar; v.a_adr = AW'(aadr); v.a_dat = ad; v.a_att = at;
    v.b_req = br; v.b_adr = AW'(badr); v.b_dat = bd; v.b_att = bt;
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t act;
    act = '{we, v_adr, v_dat, c_dat, a_ack, b_ack, err, busy};
    n_total++;
    if (act === e) n_pass++;
    else $display("FAIL %s @%0t: got we=%b adr=%0d vd=%h cd=%h aack=%b back=%b err=%b busy=%b, want we=%b adr=%0d vd=%h cd=%h aack=%b back=%b err=%b busy=%b",
                  name, $time, act.we, act.adr, act.vd, act.cd, act.a_ack, act.b_ack, act.err, act.busy,
                  e.we, e.adr, e.vd, e.cd, e.a_ack, e.b_ack, e.err, e.busy);
  endtask

  task automatic clear_inputs();
    a_req = 0; b_req = 0; clr = 0;
    a_adr = '0; b_adr = '0; a_dat = 0; a_att = 0; b_dat = 0; b_att = 0; clr_att = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Behavioural model: remaining fill writes, latched fill attribute,
  // which requester wins the next tie, and the outputs expected this cycle.
  int    m_todo;
  logic  [7:0] m_attr;
  logic  m_b_first;
  outs_t m_cur;

  task automatic model_reset();
    m_todo = 0; m_attr = 0; m_b_first = 0; m_cur = '0;
  endtask

  task automatic model_step();
    outs_t n;
    logic  ea, eb, take_a;
    n = '0;
    if (m_cur.busy && m_todo > 0) begin
      n = mko(1, CELLS - m_todo, 8'h20, m_attr, 0, 0, 0, 1);
      m_todo--;
    end else if (!m_cur.busy && clr) begin
      m_attr = clr_att;
      m_todo = CELLS - 1;
      n = mko(1, 0, 8'h20, clr_att, 0, 0, 0, 1);
    end else begin
      ea = a_req && !m_cur.a_ack;
      eb = b_req && !m_cur.b_ack;
      if (ea || eb) begin
        take_a = ea && (!eb || !m_b_first);
        m_b_first = take_a;
        if (take_a) begin
          if (int'(a_adr) < CELLS) n = mko(1, int'(a_adr), a_dat, a_att, 1, 0, 0, 0);
          else                     n = mko(0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
        end else begin
          if (int'(b_adr) < CELLS) n = mko(1, int'(b_adr), b_dat, b_att, 0, 1, 0, 0);
          else                     n = mko(0, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        end
      end
    end
    m_cur = n;
  endtask

  vec_t vecs[16];

  initial begin
    // Table of directed vectors: inputs applied for one edge, outputs
    // checked in the following cycle.
    vecs[0]  = mkv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, mko(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs[1]  = mkv(1, 5, 8'h41, 8'h07, 0, 0, 8'h00, 8'h00, mko(1, 5, 8'h41, 8'h07, 1, 0, 0, 0));
    vecs[2]  = mkv(0, 0, 8'h00, 8'h00, 1, 2000, 8'h99, 8'h88, mko(0, 0, 8'h00, 8'h00, 0, 1, 1, 0));
    vecs[3]  = mkv(0, 0, 8'h00, 8'h00, 1, 1999, 8'h55, 8'h3C, mko(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs[4]  = mkv(0, 0, 8'h00, 8'h00, 1, 1999, 8'h55, 8'h3C, mko(1, 1999, 8'h55, 8'h3C, 0, 1, 0, 0));
    vecs[5]  = mkv(1, 10, 8'h61, 8'h01, 1, 20, 8'h62, 8'h02, mko(1, 10, 8'h61, 8'h01, 1, 0, 0, 0));
    vecs[6]  = mkv(1, 10, 8'h61, 8'h01, 1, 20, 8'h62, 8'h02, mko(1, 20, 8'h62, 8'h02, 0, 1, 0, 0));
    vecs[7]  = mkv(1, 10, 8'h61, 8'h01, 1, 20, 8'h62, 8'h02, mko(1, 10, 8'h61, 8'h01, 1, 0, 0, 0));
    vecs[8]  = mkv(1, 10, 8'h61, 8'h01, 1, 20, 8'h62, 8'h02, mko(1, 20, 8'h62, 8'h02, 0, 1, 0, 0));
    vecs[9]  = mkv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, mko(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs[10] = mkv(0, 0, 8'h00, 8'h00, 1, 2047, 8'hFF, 8'hFF, mko(0, 0, 8'h00, 8'h00, 0, 1, 1, 0));
    vecs[11] = mkv(1, 0, 8'h30, 8'h40, 1, 100, 8'h31, 8'h41, mko(1, 0, 8'h30, 8'h40, 1, 0, 0, 0));
    vecs[12] = mkv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, mko(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs[13] = mkv(1, 7, 8'h70, 8'h71, 1, 8, 8'h80, 8'h81, mko(1, 8, 8'h80, 8'h81, 0, 1, 0, 0));
    vecs[14] = mkv(1, 2000, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, mko(0, 0, 8'h00, 8'h00, 1, 0, 1, 0));
    vecs[15] = mkv(1, 1, 8'h01, 8'h02, 1, 2, 8'h03, 8'h04, mko(1, 2, 8'h03, 8'h04, 0, 1, 0, 0));

    do_reset();
    check("reset", '0);
    for (int i = 0; i < 16; i++) begin
      a_req = vecs[i].a_req; a_adr = vecs[i].a_adr; a_dat = vecs[i].a_dat; a_att = vecs[i].a_att;
      b_req = vecs[i].b_req; b_adr = vecs[i].b_adr; b_dat = vecs[i].b_dat; b_att = vecs[i].b_att;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Full fill with a concurrent A request and an ignored second clear.
    do_reset();
    clr = 1; clr_att = 8'h1E;
    a_req = 1; a_adr = 11'd3; a_dat = 8'h11; a_att = 8'h22;
    @(negedge clk);
    clr = 0; clr_att = 8'h00;
    for (int i = 0; i < CELLS; i++) begin
      check("fill", mko(1, i, 8'h20, 8'h1E, 0, 0, 0, 1));
      clr = (i == 100);
      clr_att = (i == 100) ? 8'h55 : 8'h00;
      @(negedge clk);
    end
    clr = 0;
    check("post_fill_grant", mko(1, 3, 8'h11, 8'h22, 1, 0, 0, 0));
    a_req = 0;
    @(negedge clk);
    check("post_fill_idle", '0);

    // Reset in the middle of a fill.
    do_reset();
    clr = 1; clr_att = 8'h1E;
    @(negedge clk);
    clr = 0;
    for (int i = 0; i <= 500; i++) begin
      check("fill2", mko(1, i, 8'h20, 8'h1E, 0, 0, 0, 1));
      if (i < 500) @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    check("rst_mid_fill", '0);
    rst = 0;
    a_req = 1; a_adr = 11'd9; a_dat = 8'h4A; a_att = 8'h0F;
    @(negedge clk);
    check("grant_after_rst", mko(1, 9, 8'h4A, 8'h0F, 1, 0, 0, 0));
    a_req = 0;

    // Random traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      check("rand", m_cur);
      if (a_req && a_ack) a_req = 0;
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1;
        a_adr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(2000, 2047)) : AW'($urandom_range(0, 1999));
        a_dat = 8'($urandom); a_att = 8'($urandom);
      end
      if (b_req && b_ack) b_req = 0;
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1;
        b_adr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(2000, 2047)) : AW'($urandom_range(0, 1999));
        b_dat = 8'($urandom); b_att = 8'($urandom);
      end
      clr = ($urandom_range(0, 1499) == 0);
      clr_att = 8'($urandom);
      model_step();
      @(negedge clk);
    end
    check("rand_last", m_cur);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
